// File: rtl/pipelined_addsub_if.sv
// Valid/ready operand and result channels of the pipelined add/subtract unit.
// The slave modport is the unit's view; the master modport is the producer/consumer view.
interface pipelined_addsub_if #(
  parameter int WA = 6,
  parameter int WB = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] x;
  logic [WB-1:0] y;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [WA:0]   z;

  modport slave (
    input  in_valid, x, y, sub, out_ready,
    output in_ready, out_valid, z
  );

  modport master (
    output in_valid, x, y, sub, out_ready,
    input  in_ready, out_valid, z
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined unsigned add/subtract: the WA+1-bit carry chain is cut into CHUNK-bit registered
// stages, with a single global stall so all stages advance or hold together.
module pipelined_addsub #(
  parameter int WA    = 6,
  parameter int WB    = 4,
  parameter int CHUNK = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_addsub_if.slave  bus
);
  localparam int W      = WA + 1;
  localparam int STAGES = (W + CHUNK - 1) / CHUNK;

  logic         adv;
  logic [W-1:0] y_ext;

  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;
  assign y_ext        = W'(bus.y);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int RW = W - LO;
    localparam int CW = (RW < CHUNK) ? RW : CHUNK;

    // a/b hold the operand bits not yet consumed; this stage's chunk sits at the bottom
    logic [RW-1:0]      a;
    logic [RW-1:0]      b;
    logic               c_in;
    logic               v_in;
    logic [CW-1:0]      sum;
    logic [LO+CW-1:0]   r_nxt;
    logic [LO+CW-1:0]   res_p;
    logic               vld_p;

    if (k == 0) begin : g_first
      assign a     = {1'b0, bus.x};
      assign b     = bus.sub ? ~y_ext : y_ext;
      assign c_in  = bus.sub;
      assign v_in  = bus.in_valid;
      assign r_nxt = sum;
    end else begin : g_next
      assign a     = g_stage[k-1].g_fwd.xa_p;
      assign b     = g_stage[k-1].g_fwd.ya_p;
      assign c_in  = g_stage[k-1].g_fwd.cy_p;
      assign v_in  = g_stage[k-1].vld_p;
      assign r_nxt = {sum, g_stage[k-1].res_p};
    end

    if (k < STAGES - 1) begin : g_fwd
      logic             c_out;
      logic [RW-CW-1:0] xa_p;
      logic [RW-CW-1:0] ya_p;
      logic             cy_p;

      assign {c_out, sum} = {1'b0, a[CW-1:0]} + {1'b0, b[CW-1:0]} + (CW+1)'(c_in);

      always_ff @(posedge clk) begin
        if (adv) begin
          xa_p <= a[RW-1:CW];
          ya_p <= b[RW-1:CW];
          cy_p <= c_out;
        end
      end
    end else begin : g_last
      // top chunk: carry out is the discarded modulo-2^(WA+1) bit
      assign sum = a + b + RW'(c_in);
    end

    // stage k boundary: finished low result bits ride alongside the remaining operand bits
    always_ff @(posedge clk) begin
      if (adv) res_p <= r_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld_p <= 1'b0;
      else if (adv) vld_p <= v_in;
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_p;
  assign bus.z         = g_stage[STAGES-1].vld_p ? g_stage[STAGES-1].res_p : '0;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed literal checks plus a queue model compared every cycle,
// on the default build and on three extra parameter sets driven with random stalls.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_r;
  int   total = 0;
  int   bad   = 0;
  int   rx    = 0;
  longint q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint model(input longint xv, input longint yv, input logic s, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (s ? xv - yv : xv + yv) & m;
  endfunction

  pipelined_addsub_if #(.WA(6), .WB(4)) bus ();
  pipelined_addsub #(.WA(6), .WB(4), .CHUNK(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      chk("in_ready_rule", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got z=%0d expected no output", bus.z);
        end else begin
          chk("stream_z", longint'(bus.z), q[0]);
          if (bus.out_ready) begin
            void'(q.pop_front());
            rx++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(longint'(bus.x), longint'(bus.y), bus.sub, 7));
    end
  end

  task automatic drive(input logic v, input int xv, input int yv, input logic s);
    bus.in_valid = v;
    bus.x        = 6'(xv);
    bus.y        = 4'(yv);
    bus.sub      = s;
  endtask

  task automatic one(input int xv, input int yv, input logic s, input longint exp, input string nm);
    int n;
    n = 0;
    @(posedge clk); #1 drive(1'b1, xv, yv, s);
    @(posedge clk); #1 drive(1'b0, 0, 0, 1'b0);
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, longint'(n), 3);
    chk(nm, longint'(bus.z), exp);
    @(posedge clk); #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_reg
    localparam int RWA = (g == 0) ? 16 : (g == 1) ? 1 : 8;
    localparam int RWB = (g == 0) ? 16 : (g == 1) ? 1 : 3;
    localparam int RCH = (g == 0) ? 5  : (g == 1) ? 1 : 9;

    pipelined_addsub_if #(.WA(RWA), .WB(RWB)) rb ();
    pipelined_addsub #(.WA(RWA), .WB(RWB), .CHUNK(RCH)) rdut (.clk(clk), .rst_n(rst_r), .bus(rb));

    longint rq[$];
    int     rrx  = 0;
    logic   done = 1'b0;

    always @(negedge clk) begin
      if (!rst_r) rq.delete();
      else begin
        chk("reg_in_ready_rule", longint'(rb.in_ready), longint'(!rb.out_valid || rb.out_ready));
        if (rb.out_valid) begin
          if (rq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL reg_unexpected_out cfg%0d: got z=%0d expected no output", g, rb.z);
          end else begin
            chk("reg_z", longint'(rb.z), rq[0]);
            if (rb.out_ready) begin
              void'(rq.pop_front());
              rrx++;
            end
          end
        end
        if (rb.in_valid && rb.in_ready)
          rq.push_back(model(longint'(rb.x), longint'(rb.y), rb.sub, RWA + 1));
      end
    end

    initial begin
      int sent;
      sent         = 0;
      rb.in_valid  = 1'b0;
      rb.x         = '0;
      rb.y         = '0;
      rb.sub       = 1'b0;
      rb.out_ready = 1'b0;
      while (!rst_r) @(posedge clk);
      while (sent < 60) begin
        @(posedge clk); #1;
        rb.in_valid  = ($urandom % 4) != 0;
        rb.x         = RWA'($urandom);
        rb.y         = RWB'($urandom);
        rb.sub       = 1'($urandom % 2);
        rb.out_ready = ($urandom % 3) != 0;
        #1;
        if (rb.in_valid && rb.in_ready) sent++;
      end
      @(posedge clk); #1;
      rb.in_valid  = 1'b0;
      rb.out_ready = 1'b1;
      for (int i = 0; i < 100 && rq.size() != 0; i++) @(posedge clk);
      #1;
      chk("reg_drained", longint'(rq.size()), 0);
      chk("reg_count", longint'(rrx), 60);
      done = 1'b1;
    end
  end

  initial begin
    int     r0;
    int     r1;
    longint z0;
    logic   all_done;
    rst_n = 1'b0;
    rst_r = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    bus.out_ready = 1'b1;
    #3;
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_in_ready",  longint'(bus.in_ready), 1);
    chk("reset_z",         longint'(bus.z), 0);
    #9;
    rst_n = 1'b1;
    rst_r = 1'b1;

    one(63, 15, 1'b0, 64'h4E, "add_63_15");
    one(5,  9,  1'b1, 64'h7C, "sub_5_9");
    one(63, 0,  1'b1, 64'h3F, "sub_63_0");
    one(0,  15, 1'b1, 64'h71, "sub_0_15");

    r0 = rx;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, int'($urandom % 64), int'($urandom % 16), 1'($urandom % 2));
      @(posedge clk); #1;
    end
    drive(1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("stream_count_19", longint'(rx - r0), 19);
    chk("stream_last_valid", longint'(bus.out_valid), 1);
    @(posedge clk); #1;
    chk("stream_count_20", longint'(rx - r0), 20);
    chk("stream_idle", longint'(bus.out_valid), 0);

    r0 = rx;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, int'($urandom % 64), int'($urandom % 16), 1'($urandom % 2));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    drive(1'b1, 42, 7, 1'b1);
    #1;
    z0 = longint'(bus.z);
    repeat (5) begin
      chk("stall_in_ready", longint'(bus.in_ready), 0);
      chk("stall_out_valid", longint'(bus.out_valid), 1);
      chk("stall_z_hold", longint'(bus.z), z0);
      @(posedge clk); #2;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 0, 0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("stall_count", longint'(rx - r0), 5);
    chk("stall_drained", longint'(q.size()), 0);

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, int'($urandom % 64), int'($urandom % 16), 1'($urandom % 2));
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    r1 = rx;
    #1;
    chk("midreset_out_valid", longint'(bus.out_valid), 0);
    chk("midreset_in_ready",  longint'(bus.in_ready), 1);
    chk("midreset_z",         longint'(bus.z), 0);
    #4;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_no_stale", longint'(rx - r1), 0);
    chk("post_reset_idle", longint'(bus.out_valid), 0);
    one(10, 3, 1'b1, 64'h07, "post_reset_sub");

    all_done = 1'b0;
    for (int i = 0; i < 5000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_reg[0].done && g_reg[1].done && g_reg[2].done;
    end
    chk("regress_done", longint'(all_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
